// File: rtl/lcd_defs.sv
`default_nettype none
// ============================================================================
// Package     : lcd_defs
// Description : HD44780 command bytes, sequencer state encoding, step helpers.
// Revision    : 1.0
// ============================================================================
package lcd_defs;

   typedef enum logic [2:0] {
      PWR_WAIT = 3'd0,
      ISSUE    = 3'd1,
      WAIT_RDY = 3'd2,
      CLR_WAIT = 3'd3,
      IDLE     = 3'd4
   } lcd_state_t;

   localparam logic [7:0] FUNC_SET = 8'h28;
   localparam logic [7:0] ENTRY    = 8'h06;
   localparam logic [7:0] DISP_ON  = 8'h0C;
   localparam logic [7:0] CLEAR    = 8'h01;
   localparam logic [7:0] LINE1    = 8'h80;
   localparam logic [7:0] LINE2    = 8'hC0;

   localparam logic [7:0] CHAR_SPACE = 8'h20;
   localparam int         BUF_DEPTH  = 32;
   localparam int         N_INIT     = 4;
   localparam int         N_REFRESH  = 34;
   localparam int         LINE2_STEP = 17;

   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      logic [7:0] cmd;
      case (idx)
         2'd0:    cmd = FUNC_SET;
         2'd1:    cmd = ENTRY;
         2'd2:    cmd = DISP_ON;
         default: cmd = CLEAR;
      endcase
      return cmd;
   endfunction

   // Refresh step 0 is the line-1 address command and step 17 the line-2 one,
   // so characters sit one or two steps above their buffer address.
   function automatic logic [4:0] step_to_addr(input logic [5:0] step);
      logic [5:0] a;
      if (step < 6'(LINE2_STEP)) a = step - 6'd1;
      else                       a = step - 6'd2;
      return a[4:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_char_buf.sv
`default_nettype none
// ============================================================================
// Module      : lcd_char_buf
// Description : 32x8 character buffer, one write port, async read, space fill.
// Revision    : 1.0
// ============================================================================
module lcd_char_buf
   import lcd_defs::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_wr_en,
   input  logic [4:0] i_wr_addr,
   input  logic [7:0] i_wr_data,
   input  logic [4:0] i_rd_addr,
   output logic [7:0] o_rd_data
);

   logic [7:0] r_mem [BUF_DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            r_mem[i] <= CHAR_SPACE;
         end
      end else if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   // Combinational read returns the pre-write value in a write cycle.
   assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/lcd_text_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : lcd_text_sequencer
// Description : HD44780 power-on init plus two-line text refresh byte scheduler.
// Revision    : 1.0
// ============================================================================
module lcd_text_sequencer
   import lcd_defs::*;
#(
   parameter int T_PWR = 750000,
   parameter int T_CLR = 82000
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_en,
   input  logic [4:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic       refresh,
   input  logic       cmd_ready,
   output logic       cmd_start,
   output logic       cmd_rs,
   output logic       cmd_rw,
   output logic [7:0] cmd_data,
   output logic       init_done,
   output logic       busy
);

   localparam int T_MAX   = (T_PWR > T_CLR) ? T_PWR : T_CLR;
   localparam int CNT_REQ = $clog2(T_MAX + 1);
   localparam int CNT_W   = (CNT_REQ > 20) ? CNT_REQ : 20;

   lcd_state_t       r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [5:0]       r_step, w_step_nxt;
   logic             r_refresh, w_refresh_nxt;
   logic             r_pend, w_pend_nxt;
   logic             r_start, w_start_nxt;
   logic             r_rs, w_rs_nxt;
   logic [7:0]       r_data, w_data_nxt;
   logic             r_done, w_done_nxt;

   logic [4:0]       w_rd_addr;
   logic [7:0]       w_rd_data;
   logic [7:0]       w_byte;
   logic             w_byte_rs;

   lcd_char_buf u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_wr_en   (wr_en),
      .i_wr_addr (wr_addr),
      .i_wr_data (wr_data),
      .i_rd_addr (w_rd_addr),
      .o_rd_data (w_rd_data)
   );

   // Byte belonging to the current step of the active list.
   always_comb begin
      w_rd_addr = 5'd0;
      w_byte    = 8'h00;
      w_byte_rs = 1'b0;
      if (!r_refresh) begin
         w_byte = init_cmd(r_step[1:0]);
      end else if (r_step == 6'd0) begin
         w_byte = LINE1;
      end else if (r_step == 6'(LINE2_STEP)) begin
         w_byte = LINE2;
      end else begin
         w_rd_addr = step_to_addr(r_step);
         w_byte    = w_rd_data;
         w_byte_rs = 1'b1;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_step_nxt    = r_step;
      w_refresh_nxt = r_refresh;
      w_pend_nxt    = r_pend | (refresh & (r_state != IDLE));
      w_start_nxt   = 1'b0;
      w_rs_nxt      = r_rs;
      w_data_nxt    = r_data;
      w_done_nxt    = r_done;

      case (r_state)
         PWR_WAIT: begin
            if (r_cnt == CNT_W'(T_PWR - 1)) begin
               w_state_nxt   = ISSUE;
               w_cnt_nxt     = '0;
               w_step_nxt    = 6'd0;
               w_refresh_nxt = 1'b0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end

         ISSUE: begin
            if (cmd_ready) begin
               w_start_nxt = 1'b1;
               w_rs_nxt    = w_byte_rs;
               w_data_nxt  = w_byte;
               w_state_nxt = WAIT_RDY;
            end
         end

         // r_start is high only in the first WAIT_RDY cycle, when the sender
         // has not yet had a chance to drop cmd_ready.
         WAIT_RDY: begin
            if (!r_start && cmd_ready) begin
               if (!r_refresh && (r_step == 6'(N_INIT - 1))) begin
                  w_state_nxt = CLR_WAIT;
                  w_cnt_nxt   = '0;
               end else if (r_refresh && (r_step == 6'(N_REFRESH - 1))) begin
                  w_state_nxt = IDLE;
               end else begin
                  w_step_nxt  = r_step + 6'd1;
                  w_state_nxt = ISSUE;
               end
            end
         end

         CLR_WAIT: begin
            if (r_cnt == CNT_W'(T_CLR - 1)) begin
               w_done_nxt  = 1'b1;
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end

         IDLE: begin
            if (refresh || r_pend) begin
               w_pend_nxt    = 1'b0;
               w_refresh_nxt = 1'b1;
               w_step_nxt    = 6'd0;
               w_state_nxt   = ISSUE;
            end
         end

         default: begin
            w_state_nxt = PWR_WAIT;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= PWR_WAIT;
         r_cnt     <= '0;
         r_step    <= 6'd0;
         r_refresh <= 1'b0;
         r_pend    <= 1'b0;
         r_start   <= 1'b0;
         r_rs      <= 1'b0;
         r_data    <= 8'h00;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_step    <= w_step_nxt;
         r_refresh <= w_refresh_nxt;
         r_pend    <= w_pend_nxt;
         r_start   <= w_start_nxt;
         r_rs      <= w_rs_nxt;
         r_data    <= w_data_nxt;
         r_done    <= w_done_nxt;
      end
   end

   assign cmd_start = r_start;
   assign cmd_rs    = r_rs;
   assign cmd_rw    = 1'b0;
   assign cmd_data  = r_data;
   assign init_done = r_done;
   assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire
